// File: rtl/frame_pkg.sv
// Shared constants and types for the frame packer: buffer bases, frame geometry
// and the fill state machine encoding.
package frame_pkg;

    localparam logic [21:0] ADDR_A          = 22'h100000;
    localparam logic [21:0] ADDR_B          = 22'h200000;
    localparam int unsigned WORDS_PER_LINE  = 40;
    localparam int unsigned LINES_PER_FRAME = 480;
    localparam int unsigned WORDS_PER_FRAME = WORDS_PER_LINE * LINES_PER_FRAME;
    localparam int unsigned PIX_PER_WORD    = 16;
    localparam int unsigned FIFO_DEPTH      = 4;

    localparam int unsigned WORD_W  = 8 * PIX_PER_WORD;
    localparam int unsigned WCNT_W  = 15;
    localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Lines are contiguous, so a word's address is simply base plus its index.
    function automatic logic [21:0] word_addr(input logic [21:0] base,
                                              input logic [WCNT_W-1:0] idx);
        return base + 22'(idx);
    endfunction

endpackage

// File: rtl/pix_word_fifo.sv
// Small synchronous FIFO of packed pixel words. Exposes the head and the entry
// behind it so the write port can issue back-to-back requests.
module pix_word_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [WIDTH-1:0]           next_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign rd_ptr_nx = rd_ptr_q + PTR_W'(1);
    assign head_data = mem_q[rd_ptr_q];
    assign next_data = mem_q[rd_ptr_nx];

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_nx;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after a push has written it.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/frame_packer.sv
// Packs a raster stream of 8-bit palette indices into 128-bit words and writes
// them to the SDRAM back buffer (the one not being scanned out).
module frame_packer
    import frame_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = WORDS_PER_FRAME
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         new_frame,
    input  logic         frame_flip,
    input  logic         pix_valid,
    input  logic [7:0]   pix_data,
    output logic         pix_ready,
    output logic         sdram_wr,
    output logic [21:0]  sdram_addr,
    output logic [127:0] sdram_wdata,
    input  logic         sdram_ac,
    input  logic         sdram_Wait,
    output logic         busy,
    output logic         done,
    output logic         frame_err
);

    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);

    state_e              state_q, state_d;
    logic                abort_q, abort_d;
    logic                frame_err_q, frame_err_d;
    logic [21:0]         base_q, base_d;
    logic [3:0]          pix_cnt_q, pix_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WCNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic                wr_q, wr_d;
    logic [21:0]         addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;

    logic                fifo_push, fifo_pop, fifo_flush;
    logic [WORD_W-1:0]   fifo_push_data;
    logic [WORD_W-1:0]   fifo_head, fifo_next;
    logic [FCNT_W-1:0]   fifo_count;
    logic                fifo_full, fifo_empty;

    logic                pix_ready_c;
    logic                pix_accept;
    logic                in_frame;
    logic                aborting;
    logic                can_issue;

    pix_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .next_data (fifo_next),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_frame       = (state_q == ST_START) || (state_q == ST_FILL) || (state_q == ST_DRAIN);
    assign aborting       = in_frame && (new_frame || abort_q);
    assign can_issue      = !sdram_Wait && !aborting;
    assign pix_ready_c    = (state_q == ST_FILL) && !abort_q && !fifo_full;
    assign pix_accept     = pix_valid && pix_ready_c;
    assign fifo_push_data = {pix_data, pack_q[WORD_W-9:0]};

    always_comb begin
        state_d     = state_q;
        abort_d     = abort_q;
        frame_err_d = frame_err_q;
        base_d      = base_q;
        pix_cnt_d   = pix_cnt_q;
        word_cnt_d  = word_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        pack_d      = pack_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (new_frame) state_d = ST_START;
            end
            ST_START: begin
                base_d     = frame_flip ? ADDR_B : ADDR_A;
                pix_cnt_d  = '0;
                word_cnt_d = '0;
                wr_cnt_d   = '0;
                pack_d     = '0;
                state_d    = ST_FILL;
            end
            ST_FILL: begin
                if (pix_accept) begin
                    pack_d[{pix_cnt_q, 3'b000} +: 8] = pix_data;
                    pix_cnt_d = pix_cnt_q + 4'd1;
                    if (pix_cnt_q == 4'd15) begin
                        fifo_push  = 1'b1;
                        pack_d     = '0;
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                        if (word_cnt_q == LAST_WORD) state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !wr_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Write port: addr/wdata only change when a request starts.
        if (wr_q) begin
            if (sdram_ac) begin
                fifo_pop = 1'b1;
                wr_cnt_d = wr_cnt_q + WCNT_W'(1);
                if (fifo_count > FCNT_W'(1) && can_issue) begin
                    wr_d    = 1'b1;
                    addr_d  = word_addr(base_q, wr_cnt_q + WCNT_W'(1));
                    wdata_d = fifo_next;
                end else begin
                    wr_d = 1'b0;
                end
            end
        end else if (!fifo_empty && can_issue) begin
            wr_d    = 1'b1;
            addr_d  = word_addr(base_q, wr_cnt_q);
            wdata_d = fifo_head;
        end

        // A restart waits out any outstanding request, then discards all buffered pixels.
        if (in_frame && new_frame) frame_err_d = 1'b1;
        if (aborting) begin
            if (!wr_q || sdram_ac) begin
                state_d    = ST_START;
                abort_d    = 1'b0;
                fifo_flush = 1'b1;
                pix_cnt_d  = '0;
                pack_d     = '0;
            end else begin
                state_d = state_q;
                abort_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            abort_q     <= 1'b0;
            frame_err_q <= 1'b0;
            base_q      <= '0;
            pix_cnt_q   <= '0;
            word_cnt_q  <= '0;
            wr_cnt_q    <= '0;
            pack_q      <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            abort_q     <= abort_d;
            frame_err_q <= frame_err_d;
            base_q      <= base_d;
            pix_cnt_q   <= pix_cnt_d;
            word_cnt_q  <= word_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            pack_q      <= pack_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign pix_ready   = pix_ready_c;
    assign sdram_wr    = wr_q;
    assign sdram_addr  = addr_q;
    assign sdram_wdata = wdata_q;
    assign busy        = (state_q == ST_FILL) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign frame_err   = frame_err_q;

endmodule
